// File: rtl/special_queue_pkg.sv
// Shared definitions for the special queue: the 2-bit operation flag that the
// control block hands to the storage stage, plus small decode helpers so both
// sides interpret the encoding identically.
package special_queue_pkg;

  typedef logic [1:0] flag_t;

  localparam flag_t FLAG_HOLD = 2'b00;
  localparam flag_t FLAG_PUSH = 2'b01;
  localparam flag_t FLAG_POP  = 2'b10;
  localparam flag_t FLAG_BOTH = 2'b11;

  // Bit 0 requests a write, bit 1 requests a read; BOTH is simply the union.
  function automatic logic flag_has_push(flag_t f);
    return f[0];
  endfunction

  function automatic logic flag_has_pop(flag_t f);
    return f[1];
  endfunction

endpackage

// File: rtl/queue_ram.sv
// Simple dual-port storage array for the special queue.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset; clears only the read register
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata updates only on a read
//   raddr  : read address
//   rdata  : registered read data, holds between reads
// On a same-edge read/write to one address the read returns the old word.
module queue_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int Words = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [Words];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking semantics give read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/queue_storage.sv
// Storage/pointer stage of the special queue. Executes the operation flag from
// the control block (hold / push / pop / push+pop) on a circular buffer and
// returns registered full/empty so the control loop has no combinational path.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   flag       : operation, see special_queue_pkg encodings
//   din        : write data, sampled on push edges
//   dout       : registered popped data, holds between pops
//   dout_valid : one-cycle pulse when dout carries a newly popped word
//   full       : registered, count == DEPTH
//   empty      : registered, count == 0
//   count      : registered occupancy 0..DEPTH
//   ovf_err    : sticky, push while full
//   udf_err    : sticky, pop (or push+pop) while empty
module queue_storage
  import special_queue_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        flag,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam logic [ADDR_W:0] CountFull = (ADDR_W+1)'(DEPTH);

  flag_t op;
  assign op = flag_t'(flag);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic push_ok;
  logic pop_ok;
  logic ram_we;
  logic ram_re;

  // A pop frees a slot on the same edge, so push+pop on a full queue still
  // writes. Push+pop on an empty queue degrades to a plain push.
  always_comb begin
    pop_ok  = flag_has_pop(op) && !empty_q;
    push_ok = flag_has_push(op) && (!full_q || pop_ok);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // count is the sole source of full/empty, so pointer equality never
    // has to be disambiguated.
    count_d = count_q + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
    full_d  = (count_d == CountFull);
    empty_d = (count_d == '0);
    valid_d = pop_ok;

    ovf_d = ovf_q | ((op == FLAG_PUSH) && full_q);
    udf_d = udf_q | (flag_has_pop(op) && empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Reset discards the in-flight op, including its RAM write.
  assign ram_we = push_ok && !rst;
  assign ram_re = pop_ok && !rst;

  queue_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .waddr(wr_ptr_q),
    .wdata(din),
    .re   (ram_re),
    .raddr(rd_ptr_q),
    .rdata(dout)
  );

  assign dout_valid = valid_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign ovf_err    = ovf_q;
  assign udf_err    = udf_q;

  a_not_full_and_empty : assert property (@(posedge clk) disable iff (rst) !(full_q && empty_q));
  a_count_in_range : assert property (@(posedge clk) disable iff (rst) count_q <= CountFull);

endmodule
